// File: rtl/beat_pkg.sv
// Shared types and constants for the beat generator.
// Phase/beat encodings and the beat-sequencing rule.
package beat_pkg;

  localparam int CYC_W = 16;

  typedef enum logic [1:0] {
    T1 = 2'd0,
    T2 = 2'd1,
    T3 = 2'd2
  } phase_t;

  typedef enum logic [1:0] {
    W1 = 2'd0,
    W2 = 2'd1,
    W3 = 2'd2
  } beat_t;

  // Beat that follows a T3-ending edge when no halt is requested.
  function automatic beat_t next_beat(
    input beat_t b,
    input logic  s,
    input logic  l
  );
    beat_t n;
    n = W1;
    unique case (b)
      W1:      n = s ? W1 : W2;
      W2:      n = l ? W3 : W1;
      W3:      n = W1;
      default: n = W1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/beat_generator_qd_sync.sv
// Start push-button synchronizer with rising-edge detect.
// One-cycle rise_pulse per press, regardless of hold time.
module qd_sync (
  input  logic clk,
  input  logic clr,
  input  logic async_in,
  output logic rise_pulse
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= async_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign rise_pulse = r_s2 & ~r_prev;

endmodule

// File: rtl/beat_generator.sv
// Phase/beat timing generator with start/stop/step control.
// Counts completed instructions in cyc_cnt.
module beat_generator
  import beat_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             qd,
  input  logic             short,
  input  logic             long,
  input  logic             stop,
  input  logic             step,
  output logic             t1,
  output logic             t2,
  output logic             t3,
  output logic             w1,
  output logic             w2,
  output logic             w3,
  output logic             run,
  output logic [CYC_W-1:0] cyc_cnt
);

  phase_t           r_phase;
  beat_t            r_beat;
  logic             r_run;
  logic [CYC_W-1:0] r_cyc;

  phase_t w_phase_d;
  beat_t  w_beat_d;
  logic   w_run_d;
  logic   w_done;
  logic   w_end;
  logic   w_rise;

  qd_sync u_qd_sync (
    .clk        (clk),
    .clr        (clr),
    .async_in   (qd),
    .rise_pulse (w_rise)
  );

  assign w_end = r_run && (r_phase == T3);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_phase <= T1;
      r_beat  <= W1;
      r_run   <= 1'b0;
      r_cyc   <= '0;
    end else begin
      r_phase <= w_phase_d;
      r_beat  <= w_beat_d;
      r_run   <= w_run_d;
      if (w_done)
        r_cyc <= r_cyc + CYC_W'(1);
    end
  end

  always_comb begin
    w_phase_d = r_phase;
    w_beat_d  = r_beat;
    w_run_d   = r_run;
    w_done    = 1'b0;
    if (!r_run) begin
      w_phase_d = T1;
      if (w_rise)
        w_run_d = 1'b1;
    end else begin
      unique case (r_phase)
        T1:      w_phase_d = T2;
        T2:      w_phase_d = T3;
        T3:      w_phase_d = T1;
        default: w_phase_d = T1;
      endcase
      if (w_end) begin
        // stop overrides short/long and still closes the instruction
        w_beat_d = stop ? W1 : next_beat(r_beat, short, long);
        w_done   = (w_beat_d == W1);
        if (stop || (step && w_done))
          w_run_d = 1'b0;
      end
    end
  end

  assign run     = r_run;
  assign t1      = r_run && (r_phase == T1);
  assign t2      = r_run && (r_phase == T2);
  assign t3      = r_run && (r_phase == T3);
  assign w1      = (r_beat == W1);
  assign w2      = (r_beat == W2);
  assign w3      = (r_beat == W3);
  assign cyc_cnt = r_cyc;

endmodule
